// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
//   Shared definitions for the UART TX feeder and the TX frame path:
//   default byte width / FIFO depth and the launch FSM state encodings.
package uart_tx_feeder_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } launch_state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// uart_tx_fifo_mem
//   Synchronous FIFO holding bytes waiting for the UART TX path.
//   Ports:
//     CLK, RST        clock (rising edge), async active-low reset
//     WR_EN, WR_DATA  write strobe and byte to enqueue
//     POP             advance the read pointer (driven by the launch FSM)
//     HEAD            byte at the read pointer
//     FULL, EMPTY     occupancy flags decoded from COUNT
//     COUNT           current occupancy (0..DEPTH)
//     DROP            high in a cycle where WR_EN is rejected because FULL
module uart_tx_fifo_mem
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  POP,
  output logic [DATA_WIDTH-1:0] HEAD,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  DROP
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  pop_acc;

  // FULL/EMPTY come from the registered count, so a pop on the same edge
  // does not open room for a write presented while full.
  assign FULL    = (count == FULL_COUNT);
  assign EMPTY   = (count == '0);
  assign COUNT   = count;
  assign wr_acc  = WR_EN & ~FULL;
  assign pop_acc = POP & ~EMPTY;
  assign DROP    = WR_EN & FULL;
  assign HEAD    = mem[rd_ptr];

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte buffer and launch controller in front of the UART TX frame FSM.
//   Bytes are queued in a FIFO and launched one at a time: P_DATA is loaded
//   with the FIFO head and DATA_VALID strobes for one cycle; the next byte
//   is launched only after TX_BUSY has risen and fallen again.
//   Ports:
//     CLK, RST        clock (rising edge), async active-low reset
//     WR_EN, WR_DATA  system-side write strobe and byte
//     TX_BUSY         registered BUSY from the TX frame FSM
//     FULL, EMPTY     FIFO flags
//     COUNT           FIFO occupancy
//     DROP            write rejected because FIFO full
//     P_DATA          byte presented to the TX path, stable for the frame
//     DATA_VALID      one-cycle launch strobe
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | waiting for a queued byte and TX_BUSY low
//   ST_LAUNCH    | DATA_VALID high for one cycle, P_DATA just loaded
//   ST_WAIT_BUSY | waiting for the TX path to raise TX_BUSY
//   ST_WAIT_DONE | frame in progress, waiting for TX_BUSY to drop
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  TX_BUSY,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  DROP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID
);

  launch_state_t         state;
  launch_state_t         state_nxt;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  uart_tx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .POP     (pop),
    .HEAD    (head),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT),
    .DROP    (DROP)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // P_DATA only moves on the IDLE->LAUNCH edge, which is exactly when pop
  // is high, so the byte is held for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA <= '0;
    end else if (pop) begin
      P_DATA <= head;
    end
  end

  // DATA_VALID is decoded from the state register so it drops together
  // with RST rather than waiting for a clock edge.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    DATA_VALID = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!EMPTY && !TX_BUSY) begin
          pop       = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        DATA_VALID = 1'b1;
        state_nxt  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_EN;
  logic [7:0] WR_DATA;
  logic       TX_BUSY;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] COUNT;
  logic       DROP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;

  // TX path model: BUSY rises 2 cycles after DATA_VALID, lasts busy_len cycles.
  logic tx_force;
  logic tx_auto;
  logic model_busy;
  int   busy_len;
  int   cyc;

  int checks = 0;
  int errors = 0;

  logic [7:0] launched[$];
  int         launch_cyc[$];

  assign TX_BUSY = tx_force | model_busy;

  always #5 CLK = ~CLK;

  uart_tx_feeder dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_EN      (WR_EN),
    .WR_DATA    (WR_DATA),
    .TX_BUSY    (TX_BUSY),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .COUNT      (COUNT),
    .DROP       (DROP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID)
  );

  initial begin
    int delay;
    int bcnt;
    delay      = 0;
    bcnt       = 0;
    model_busy = 1'b0;
    cyc        = 0;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (RST !== 1'b1) begin
        delay = 0;
        bcnt  = 0;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) bcnt = busy_len;
      end
      if (bcnt > 0) begin
        model_busy = 1'b1;
        bcnt--;
      end else begin
        model_busy = 1'b0;
      end
      @(negedge CLK);
      if (DATA_VALID === 1'b1) begin
        launched.push_back(P_DATA);
        launch_cyc.push_back(cyc);
        if (tx_auto) delay = 2;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_write(input logic [7:0] b);
    @(posedge CLK);
    #1;
    WR_EN   = 1'b1;
    WR_DATA = b;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      WR_EN = 1'b0;
    end
  endtask

  task automatic wait_launches(input int n, input int budget);
    int k;
    k = 0;
    while (launched.size() < n && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
    end
    checks++;
    if (launched.size() < n) begin
      errors++;
      $display("FAIL launch_timeout: got %0d launches, required %0d", launched.size(), n);
    end
  endtask

  task automatic clear_log();
    launched.delete();
    launch_cyc.delete();
  endtask

  task automatic test_reset();
    RST = 1'b0; WR_EN = 1'b0; WR_DATA = 8'h00;
    tx_force = 1'b0; tx_auto = 1'b0; busy_len = 0;
    #2;
    checks++; if (COUNT !== 4'd0)      begin errors++; $display("FAIL rst_count: got %0d required 0", COUNT); end
    checks++; if (EMPTY !== 1'b1)      begin errors++; $display("FAIL rst_empty: got %b required 1", EMPTY); end
    checks++; if (FULL !== 1'b0)       begin errors++; $display("FAIL rst_full: got %b required 0", FULL); end
    checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", DATA_VALID); end
    checks++; if (P_DATA !== 8'h00)    begin errors++; $display("FAIL rst_pdata: got %h required 00", P_DATA); end
    checks++; if (DROP !== 1'b0)       begin errors++; $display("FAIL rst_drop: got %b required 0", DROP); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    clear_log();
    idle_cycles(10);
    @(negedge CLK); #1;
    checks++; if (EMPTY !== 1'b1)       begin errors++; $display("FAIL idle_empty: got %b required 1", EMPTY); end
    checks++; if (COUNT !== 4'd0)       begin errors++; $display("FAIL idle_count: got %0d required 0", COUNT); end
    checks++; if (P_DATA !== 8'h00)     begin errors++; $display("FAIL idle_pdata: got %h required 00", P_DATA); end
    checks++; if (launched.size() != 0) begin errors++; $display("FAIL idle_no_launch: got %0d launches required 0", launched.size()); end
  endtask

  task automatic test_single();
    int w;
    clear_log();
    tx_auto = 1'b1; busy_len = 11;
    drive_write(8'hA5);
    w = cyc;
    idle_cycles(1);
    wait_launches(1, 20);
    if (launched.size() >= 1) begin
      checks++; if (launched[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h required a5", launched[0]); end
      checks++; if (launch_cyc[0] - w != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", launch_cyc[0] - w); end
    end
    idle_cycles(6);
    checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL single_pdata_mid: got %h required a5", P_DATA); end
    idle_cycles(20);
    checks++; if (launched.size() != 1) begin errors++; $display("FAIL single_one_pulse: got %0d launch cycles required 1", launched.size()); end
    checks++; if (P_DATA !== 8'hA5)     begin errors++; $display("FAIL single_pdata_end: got %h required a5", P_DATA); end
    checks++; if (COUNT !== 4'd0)       begin errors++; $display("FAIL single_count: got %0d required 0", COUNT); end
  endtask

  task automatic test_queue_order();
    logic [7:0] exp [3];
    int w;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    clear_log();
    tx_auto = 1'b1; busy_len = 10;
    drive_write(8'h11);
    w = cyc;
    drive_write(8'h22);
    drive_write(8'h33);
    idle_cycles(1);
    wait_launches(3, 80);
    if (launched.size() >= 3) begin
      checks++; if (launch_cyc[0] - w != 2) begin errors++; $display("FAIL order_first_latency: got %0d required 2", launch_cyc[0] - w); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (launched[i] !== exp[i]) begin errors++; $display("FAIL order_data[%0d]: got %h required %h", i, launched[i], exp[i]); end
      end
      // launch, 1 wait, 10 busy, 1 done, 1 idle -> next launch 14 cycles later
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (launch_cyc[i] - launch_cyc[i-1] != 14) begin errors++; $display("FAIL order_gap[%0d]: got %0d required 14", i, launch_cyc[i] - launch_cyc[i-1]); end
      end
    end
    idle_cycles(20);
  endtask

  task automatic test_overflow();
    clear_log();
    tx_auto = 1'b0; tx_force = 1'b1;
    for (int i = 0; i < 8; i++) drive_write(8'(i));
    @(negedge CLK);
    checks++; if (FULL !== 1'b0)   begin errors++; $display("FAIL ovf_not_full_at7: got %b required 0", FULL); end
    checks++; if (COUNT !== 4'd7)  begin errors++; $display("FAIL ovf_count7: got %0d required 7", COUNT); end
    drive_write(8'h08);
    @(negedge CLK);
    checks++; if (FULL !== 1'b1)   begin errors++; $display("FAIL ovf_full: got %b required 1", FULL); end
    checks++; if (DROP !== 1'b1)   begin errors++; $display("FAIL ovf_drop: got %b required 1", DROP); end
    checks++; if (COUNT !== 4'd8)  begin errors++; $display("FAIL ovf_count8: got %0d required 8", COUNT); end
    idle_cycles(1);
    @(negedge CLK);
    checks++; if (DROP !== 1'b0)   begin errors++; $display("FAIL ovf_drop_clear: got %b required 0", DROP); end
    checks++; if (COUNT !== 4'd8)  begin errors++; $display("FAIL ovf_count_hold: got %0d required 8", COUNT); end
    tx_auto = 1'b1; busy_len = 3; tx_force = 1'b0;
    wait_launches(8, 120);
    for (int i = 0; i < 8; i++) begin
      if (i < launched.size()) begin
        checks++;
        if (launched[i] !== 8'(i)) begin errors++; $display("FAIL ovf_data[%0d]: got %h required %h", i, launched[i], 8'(i)); end
      end
    end
    idle_cycles(12);
    checks++; if (launched.size() != 8) begin errors++; $display("FAIL ovf_launch_count: got %0d required 8", launched.size()); end
    checks++; if (EMPTY !== 1'b1)       begin errors++; $display("FAIL ovf_drained: got %b required 1", EMPTY); end
  endtask

  task automatic test_simul_write_pop();
    logic [7:0] exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'h5A;
    clear_log();
    tx_force = 1'b1; tx_auto = 1'b1; busy_len = 4;
    drive_write(8'hA1);
    drive_write(8'hB2);
    drive_write(8'hC3);
    @(posedge CLK);
    #1;
    WR_EN = 1'b1; WR_DATA = 8'h5A; tx_force = 1'b0;
    @(negedge CLK);
    checks++; if (COUNT !== 4'd3) begin errors++; $display("FAIL simul_pre_count: got %0d required 3", COUNT); end
    idle_cycles(1);
    @(negedge CLK);
    checks++; if (COUNT !== 4'd3)      begin errors++; $display("FAIL simul_count: got %0d required 3", COUNT); end
    checks++; if (DATA_VALID !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b required 1", DATA_VALID); end
    checks++; if (P_DATA !== 8'hA1)    begin errors++; $display("FAIL simul_pdata: got %h required a1", P_DATA); end
    wait_launches(4, 60);
    for (int i = 0; i < 4; i++) begin
      if (i < launched.size()) begin
        checks++;
        if (launched[i] !== exp[i]) begin errors++; $display("FAIL simul_data[%0d]: got %h required %h", i, launched[i], exp[i]); end
      end
    end
    idle_cycles(15);
  endtask

  task automatic test_wrap_and_reset();
    int g;
    int n;
    int w;
    clear_log();
    tx_force = 1'b0; tx_auto = 1'b1; busy_len = 2;
    for (int i = 0; i < 20; i++) begin
      drive_write(8'h40 + 8'(i));
      idle_cycles(1);
      g = 0;
      while (COUNT >= 4'd4 && g < 100) begin
        idle_cycles(1);
        g++;
      end
    end
    wait_launches(20, 300);
    for (int i = 0; i < 20; i++) begin
      if (i < launched.size()) begin
        checks++;
        if (launched[i] !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h required %h", i, launched[i], 8'h40 + 8'(i)); end
      end
    end
    idle_cycles(10);

    clear_log();
    busy_len = 10;
    drive_write(8'hC3);
    drive_write(8'h3C);
    idle_cycles(1);
    wait_launches(1, 20);
    idle_cycles(4);
    checks++; if (COUNT !== 4'd1)   begin errors++; $display("FAIL midrst_pre_count: got %0d required 1", COUNT); end
    checks++; if (P_DATA !== 8'hC3) begin errors++; $display("FAIL midrst_pre_pdata: got %h required c3", P_DATA); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", DATA_VALID); end
    checks++; if (COUNT !== 4'd0)      begin errors++; $display("FAIL midrst_count: got %0d required 0", COUNT); end
    checks++; if (EMPTY !== 1'b1)      begin errors++; $display("FAIL midrst_empty: got %b required 1", EMPTY); end
    checks++; if (P_DATA !== 8'h00)    begin errors++; $display("FAIL midrst_pdata: got %h required 00", P_DATA); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    n = launched.size();
    idle_cycles(15);
    checks++; if (launched.size() != n) begin errors++; $display("FAIL postrst_no_launch: got %0d launches required %0d", launched.size(), n); end
    drive_write(8'h77);
    w = cyc;
    idle_cycles(1);
    wait_launches(n + 1, 20);
    if (launched.size() > n) begin
      checks++; if (launched[n] !== 8'h77)     begin errors++; $display("FAIL postrst_data: got %h required 77", launched[n]); end
      checks++; if (launch_cyc[n] - w != 2)    begin errors++; $display("FAIL postrst_latency: got %0d required 2", launch_cyc[n] - w); end
    end
    idle_cycles(20);
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue_order();
    test_overflow();
    test_simul_write_pop();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
